// File: rtl/ahb2_pkg.sv
// Shared AHB2 encodings, the slave state type and the byte-lane helper
// used by the SRAM slave.
package ahb2_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slv_state_t;

    // Little-endian byte-lane enables for a legal (aligned) transfer.
    function automatic logic [3:0] lane_enables(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << off;
            HSIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb2_sram_mem.sv
// Synchronous byte-enable RAM: one write port, one registered read port.
// A read of the word being written in the same cycle returns the old word.
module ahb2_sram_mem #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int DW    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW/8-1:0] we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic            re_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [DW-1:0]   rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Byte-lane write; only enabled lanes are updated.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DW/8; i++) begin
            if (we_i[i]) begin
                mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
        end
    end

    // Registered read; the output holds when no read is requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb2_sram_slv.sv
// AHB2 slave in front of a word-addressed SRAM. Inserts WAIT_STATES low
// cycles before each OKAY data phase, answers illegal transfers with the
// two-cycle ERROR response, and forwards a committing write into a read
// of the same word accepted at the same edge.
module ahb2_sram_slv
    import ahb2_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [3:0]        hprot,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hreadyi,
    output logic [DATA_W-1:0] hrdata,
    output logic [1:0]        hresp,
    output logic              hreadyo
);

    localparam int AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int IDX_W = ADDR_W - 2;
    localparam int NB    = DATA_W / 8;

    slv_state_t        state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic [AW-1:0]     addr_q;
    logic [1:0]        off_q;
    logic [2:0]        size_q;
    logic              write_q;

    logic              fwd_q;
    logic [NB-1:0]     fwd_be_q;
    logic [DATA_W-1:0] fwd_data_q;

    logic [IDX_W-1:0]  word_idx;
    logic              ready_state;
    logic              accept;
    logic              req_err;
    logic              commit;
    logic              rd_en;
    logic              same_idx;
    logic [NB-1:0]     mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              unused_ok;

    // Burst type and protection carry no meaning for a flat SRAM.
    assign unused_ok = ^{hburst, hprot};

    assign word_idx    = haddr[ADDR_W-1:2];
    assign ready_state = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
    assign accept      = ready_state && hsel && hreadyi && htrans[1];

    assign req_err = (word_idx >= IDX_W'(MEM_DEPTH))
                   || (hsize > HSIZE_WORD)
                   || ((hsize == HSIZE_HALF) && haddr[0])
                   || ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));

    // A write lands at the closing edge of its DATA cycle; reset drops it.
    assign commit   = (state_q == ST_DATA) && write_q && hreadyi;
    assign mem_we   = (commit && !rst) ? lane_enables(size_q, off_q) : '0;
    assign rd_en    = accept && !req_err && !hwrite && !rst;
    assign same_idx = commit && (haddr[AW+1:2] == addr_q);

    // Next-state and response decode; outputs depend only on state_q.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        hreadyo = 1'b1;
        hresp   = HRESP_OKAY;
        case (state_q)
            ST_WAIT: begin
                hreadyo = 1'b0;
                if (wait_q == 4'd0) begin
                    state_d = ST_DATA;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_ERR1: begin
                hreadyo = 1'b0;
                hresp   = HRESP_ERROR;
                state_d = ST_ERR2;
            end
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (state_q == ST_ERR2) begin
                    hresp = HRESP_ERROR;
                end
                if (hreadyi) begin
                    if (accept) begin
                        if (req_err) begin
                            state_d = ST_ERR1;
                        end else if (WAIT_STATES > 0) begin
                            state_d = ST_WAIT;
                            wait_d  = 4'(WAIT_STATES - 1);
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and wait-state counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Address-phase capture for the data phase that follows.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q <= 1'b0;
        end else if (accept) begin
            addr_q  <= haddr[AW+1:2];
            off_q   <= haddr[1:0];
            size_q  <= hsize;
            write_q <= hwrite && !req_err;
        end
    end

    // Remember whether the word being read is also being written this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_q <= 1'b0;
        end else if (rd_en) begin
            fwd_q      <= same_idx;
            fwd_be_q   <= mem_we;
            fwd_data_q <= hwdata;
        end
    end

    ahb2_sram_mem #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW),
        .DW    (DATA_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we),
        .waddr_i (addr_q),
        .wdata_i (hwdata),
        .re_i    (rd_en),
        .raddr_i (haddr[AW+1:2]),
        .rdata_o (mem_rdata)
    );

    // Merge forwarded write lanes over the old word read from the RAM.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign hrdata[gi*8 +: 8] = (fwd_q && fwd_be_q[gi]) ? fwd_data_q[gi*8 +: 8]
                                                               : mem_rdata[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: tb/tb_ahb2_sram_slv.sv
// Bench for ahb2_sram_slv: a zero-wait instance driven from a vector table
// and a two-wait instance driven by hand-written sequences. Expectations are
// queued as each address phase is driven and checked when its data phase ends.
module tb_ahb2_sram_slv;
    import ahb2_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        force_low;
    int          cur;

    logic        hsel0, hsel2, hreadyi0, hreadyi2, hreadyo0, hreadyo2;
    logic [1:0]  hresp0, hresp2;
    logic [31:0] hrdata0, hrdata2;
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rdat;

    assign hsel0    = hsel && (cur == 0);
    assign hsel2    = hsel && (cur == 2);
    assign hreadyi0 = hreadyo0 && !force_low;
    assign hreadyi2 = hreadyo2 && !force_low;
    assign rdy      = (cur == 0) ? hreadyo0 : hreadyo2;
    assign resp     = (cur == 0) ? hresp0   : hresp2;
    assign rdat     = (cur == 0) ? hrdata0  : hrdata2;

    ahb2_sram_slv #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hwdata(hwdata), .hreadyi(hreadyi0), .hrdata(hrdata0), .hresp(hresp0),
        .hreadyo(hreadyo0)
    );

    ahb2_sram_slv #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(1024), .WAIT_STATES(2)) u_dut2 (
        .clk(clk), .rst(rst), .hsel(hsel2), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hwdata(hwdata), .hreadyi(hreadyi2), .hrdata(hrdata2), .hresp(hresp2),
        .hreadyo(hreadyo2)
    );

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          lows;
    } exp_t;

    typedef struct {
        string       name;
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lows;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Wait for the end of the pending data phase and check it.
    task automatic complete();
        exp_t e;
        int   lows;
        logic low_bad;
        lows    = 0;
        low_bad = 1'b0;
        while (!rdy && lows < 40) begin
            if (sb.size() > 0 && resp !== sb[0].resp) low_bad = 1'b1;
            lows++;
            tick();
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check32({e.name, ".lows"},    lows, e.lows);
            check32({e.name, ".lowresp"}, {31'd0, low_bad}, 32'd0);
            check32({e.name, ".hresp"},   {30'd0, resp}, {30'd0, e.resp});
            check32({e.name, ".hrdata"},  rdat, e.rdata);
            $display("XFER %s dut%0d lows=%0d hresp=%0d hrdata=%h", e.name, cur, lows, resp, rdat);
        end else begin
            check32("idle_ready", lows, 0);
        end
    endtask

    task automatic bus(input string nm, input logic s, input logic [1:0] tr, input logic w,
                       input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic [1:0] ep, input int el);
        exp_t e;
        complete();
        hsel   = s;
        htrans = tr;
        hwrite = w;
        hsize  = sz;
        haddr  = a;
        tick();
        hwdata  = wd;
        e.name  = nm;
        e.rdata = er;
        e.resp  = ep;
        e.lows  = el;
        sb.push_back(e);
    endtask

    task automatic drain();
        complete();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        tick();
        hwdata = '0;
    endtask

    task automatic addv(input string nm, input logic s, input logic [1:0] tr, input logic w,
                        input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic [1:0] ep, input int el);
        vec_t v;
        v = '{nm, s, tr, w, sz, a, wd, er, ep, el};
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
        hsize = HSIZE_WORD; hburst = '0; hprot = '0; hwdata = '0; force_low = 1'b0; cur = 0;

        // Table for the zero-wait instance; hrdata column is the value expected
        // when that transfer's data phase ends (held value for non-reads).
        addv("wr_w10",     1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10,  32'hDEADBEEF, 32'h0,        HRESP_OKAY,  0);
        addv("rd_fwd10",   1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10,  32'h0,        32'hDEADBEEF, HRESP_OKAY,  0);
        addv("wr_w10b",    1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10,  32'h11223344, 32'hDEADBEEF, HRESP_OKAY,  0);
        addv("wr_b13",     1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h13,  32'hAA555555, 32'hDEADBEEF, HRESP_OKAY,  0);
        addv("rd_10a",     1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10,  32'h0,        32'hAA223344, HRESP_OKAY,  0);
        addv("wr_h10",     1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h10,  32'hFFFF5566, 32'hAA223344, HRESP_OKAY,  0);
        addv("idle",       1, HTRANS_IDLE,   0, HSIZE_WORD, 32'h10,  32'h0,        32'hAA223344, HRESP_OKAY,  0);
        addv("rd_10b",     1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10,  32'h0,        32'hAA225566, HRESP_OKAY,  0);
        addv("err_w02",    1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h02,  32'h99999999, 32'hAA225566, HRESP_ERROR, 1);
        addv("err_rd_oob", 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h1000,32'h0,        32'hAA225566, HRESP_ERROR, 1);
        addv("busy",       1, HTRANS_BUSY,   1, HSIZE_WORD, 32'h10,  32'h0,        32'hAA225566, HRESP_OKAY,  0);
        addv("nosel",      0, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10,  32'h12345678, 32'hAA225566, HRESP_OKAY,  0);
        addv("err_h11",    1, HTRANS_NONSEQ, 0, HSIZE_HALF, 32'h11,  32'h0,        32'hAA225566, HRESP_ERROR, 1);
        addv("err_sz3",    1, HTRANS_NONSEQ, 0, 3'b011,     32'h10,  32'h0,        32'hAA225566, HRESP_ERROR, 1);
        addv("rd_10c",     1, HTRANS_SEQ,    0, HSIZE_WORD, 32'h10,  32'h0,        32'hAA225566, HRESP_OKAY,  0);
        addv("wr_w14",     1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h14,  32'hCAFEF00D, 32'hAA225566, HRESP_OKAY,  0);
        addv("rd_b16",     1, HTRANS_NONSEQ, 0, HSIZE_BYTE, 32'h16,  32'h0,        32'hCAFEF00D, HRESP_OKAY,  0);
        addv("wr_ffc",     1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'hFFC, 32'h0F0F0F0F, 32'hCAFEF00D, HRESP_OKAY,  0);
        addv("rd_ffc",     1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'hFFC, 32'h0,        32'h0F0F0F0F, HRESP_OKAY,  0);
        addv("rd_10d",     1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10,  32'h0,        32'hAA225566, HRESP_OKAY,  0);

        repeat (2) tick();
        check32("rst.hreadyo0", {31'd0, hreadyo0}, 32'd1);
        check32("rst.hresp0",   {30'd0, hresp0},   32'd0);
        check32("rst.hrdata0",  hrdata0,           32'd0);
        check32("rst.hreadyo2", {31'd0, hreadyo2}, 32'd1);
        check32("rst.hresp2",   {30'd0, hresp2},   32'd0);
        check32("rst.hrdata2",  hrdata2,           32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            bus(tbl[i].name, tbl[i].sel, tbl[i].trans, tbl[i].wr, tbl[i].size, tbl[i].addr,
                tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_resp, tbl[i].exp_lows);
        end
        drain();

        // hreadyi held low with a selected NONSEQ write: nothing is accepted.
        force_low = 1'b1;
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD;
        haddr = 32'h10; hwdata = 32'h77777777;
        tick();
        check32("rdyi_low1.hreadyo", {31'd0, hreadyo0}, 32'd1);
        check32("rdyi_low1.hresp",   {30'd0, hresp0},   32'd0);
        tick();
        check32("rdyi_low2.hreadyo", {31'd0, hreadyo0}, 32'd1);
        check32("rdyi_low2.hresp",   {30'd0, hresp0},   32'd0);
        force_low = 1'b0; hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
        tick();
        bus("rd_after_rdyi", 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0, 32'hAA225566, HRESP_OKAY, 0);
        drain();

        // Two-wait instance: wait-state count, forwarding across waits.
        cur = 2;
        tick();
        bus("ws2_wr0",  1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h0,  32'h0BADF00D, 32'h0,        HRESP_OKAY, 2);
        bus("ws2_rd0",  1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h0,  32'h0,        32'h0BADF00D, HRESP_OKAY, 2);
        bus("ws2_wr20", 1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h20, 32'h13579BDF, 32'h0BADF00D, HRESP_OKAY, 2);
        drain();

        // Reset lands while a write to 0x20 sits in its wait state.
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD; haddr = 32'h20;
        tick();
        hwdata = 32'h2468ACE0; hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check32("midrst.hreadyo", {31'd0, hreadyo2}, 32'd1);
        check32("midrst.hresp",   {30'd0, hresp2},   32'd0);
        check32("midrst.hrdata",  hrdata2,           32'd0);
        tick();
        bus("ws2_rd0b", 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h0,  32'h0, 32'h0BADF00D, HRESP_OKAY, 2);
        bus("ws2_rd20", 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h20, 32'h0, 32'h13579BDF, HRESP_OKAY, 2);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
